// File: rtl/burst_seq_pkg.sv
// rtl/burst_seq_pkg.sv - shared types and constants for the burst group sequencer
package burst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int BEATS_PER_GROUP = 4;
  localparam int BEAT_W          = 2;

endpackage

// File: rtl/burst_group_sequencer_if.sv
// rtl/burst_group_sequencer_if.sv - control and beat handshake bundle for the burst group sequencer
interface burst_group_sequencer_if #(
  parameter int GROUP_W = 4
) ();

  logic               start;
  logic [GROUP_W-1:0] num_groups;
  logic               abort;
  logic               beat_ready;
  logic               busy;
  logic               beat_valid;
  logic [1:0]         beat_idx;
  logic [GROUP_W-1:0] group_idx;
  logic               beat_cout;
  logic               last_beat;
  logic               done;

  modport master (
    output start, num_groups, abort, beat_ready,
    input  busy, beat_valid, beat_idx, group_idx, beat_cout, last_beat, done
  );

  modport slave (
    input  start, num_groups, abort, beat_ready,
    output busy, beat_valid, beat_idx, group_idx, beat_cout, last_beat, done
  );

endinterface

// File: rtl/beat_counter.sv
// rtl/beat_counter.sv - 2-bit wrapping beat counter with synchronous clear and wrap carry
module beat_counter
  import burst_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [BEAT_W-1:0] cnt,
  output logic              carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + BEAT_W'(1);
    end
  end

  assign carry = (cnt == BEAT_W'(BEATS_PER_GROUP - 1));

endmodule

// File: rtl/burst_group_sequencer.sv
// rtl/burst_group_sequencer.sv - issues bursts of 4-beat groups over a valid/ready handshake
module burst_group_sequencer
  import burst_seq_pkg::*;
#(
  parameter int GROUP_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  burst_group_sequencer_if.slave  bus
);

  seq_state_t         state_q, state_d;
  logic [GROUP_W-1:0] ngrp_q;
  logic [GROUP_W-1:0] grp_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               beat_carry;
  logic               start_acc;
  logic               transfer;
  logic               final_beat;
  logic               beat_en;
  logic               clr;

  assign start_acc  = (state_q == IDLE) && bus.start;
  // abort wins over a same-cycle handshake
  assign transfer   = (state_q == RUN) && bus.beat_ready && !bus.abort;
  assign final_beat = beat_carry && (grp_q == ngrp_q - GROUP_W'(1));
  // the final beat leaves both indices parked on their last values
  assign beat_en    = transfer && !final_beat;
  assign clr        = start_acc || ((state_q != IDLE) && (state_d == IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.num_groups == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (transfer && final_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ngrp_q <= '0;
      grp_q  <= '0;
    end else begin
      if (start_acc) begin
        ngrp_q <= bus.num_groups;
      end
      if (clr) begin
        grp_q <= '0;
      end else if (beat_en && beat_carry) begin
        grp_q <= grp_q + GROUP_W'(1);
      end
    end
  end

  beat_counter u_beat_counter (
    .clk   (clk),
    .rst_n (rst),
    .clr   (clr),
    .en    (beat_en),
    .cnt   (beat_q),
    .carry (beat_carry)
  );

  assign bus.busy       = (state_q != IDLE);
  assign bus.beat_valid = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.beat_idx   = beat_q;
  assign bus.group_idx  = grp_q;
  assign bus.beat_cout  = bus.beat_valid && beat_carry;
  assign bus.last_beat  = bus.beat_valid && final_beat;

endmodule
